uart_tx_param: RTL and testbench

Parametrised next-generation UART transmitter with a TX FIFO and runtime-selectable frame format: 5–9 data bits, none/even/odd parity, 1 or 2 stop bits, and a runtime baud rate. Software-facing logic pushes characters into the FIFO. The block serialises them LSB-first onto o_Tx_Serial, back-to-back, with no idle gap between frames. It sits between the register-interface glue and the pin and drives the RS-485 transmit enable.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 64 ++++++
 rtl/uart_tx_param.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: parity codes, FSM states, divisor floor.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int MIN_CLKS_PER_BIT_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_CLEANUP
    } tx_state_t;

    // Legal character widths are 5..9; anything else falls back to 8.
    function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits);
        return ((bits >= 4'd5) && (bits <= 4'd9)) ? bits : 4'd8;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Generic circular buffer with first-word-fall-through read data and occupancy count.
// Latency: a write is visible on o_Rd_Dat / o_Empty one cycle after the write edge.
// Backpressure: writes while full and reads while empty are ignored; full is judged before a same-cycle read.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset_n,
    input  logic                     i_Wr_En,
    input  logic [WIDTH-1:0]         i_Wr_Dat,
    input  logic                     i_Rd_En,
    output logic [WIDTH-1:0]         o_Rd_Dat,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [$clog2(DEPTH):0]   o_Level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_wr;
    logic             w_rd;

    assign o_Full   = (r_level == LVL_FULL);
    assign o_Empty  = (r_level == '0);
    assign o_Level  = r_level;
    assign o_Rd_Dat = r_mem[r_rd_ptr];
    assign w_wr     = i_Wr_En && !o_Full;
    assign w_rd     = i_Rd_En && !o_Empty;

    // Storage array; contents need no reset since the level gates every read.
    always_ff @(posedge i_Clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_Wr_Dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks push/pop balance.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with TX FIFO, runtime 5-9 data bits, parity, 1/2 stop bits and baud divisor.
// Latency: character written at edge N drives the start bit from edge N+2; frames run back-to-back.
// Backpressure: o_Tx_Ready low when FIFO full; writes while full are dropped and set sticky o_Overflow.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ      = 50_000_000,
    parameter int FIFO_DEPTH       = 16,
    parameter int MIN_CLKS_PER_BIT = MIN_CLKS_PER_BIT_DEF
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset_n,
    input  logic [31:0]                   i_BAUD,
    input  logic [3:0]                    i_Data_Bits,
    input  logic [1:0]                    i_Parity,
    input  logic                          i_Stop_Bits,
    input  logic                          i_Tx_DV,
    input  logic [8:0]                    i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Level,
    output logic                          o_Overflow,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Enable,
    output logic                          o_Tx_Done
);

    localparam logic [31:0] MIN_DIV = 32'(MIN_CLKS_PER_BIT);

    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [8:0]  w_fifo_head;
    logic        w_pop;

    logic [31:0] w_den;
    logic [31:0] w_quot;
    logic [31:0] w_div_calc;
    logic [31:0] r_div;

    logic [3:0]  w_nbits_in;
    logic [9:0]  w_mask_wide;
    logic [8:0]  w_char_in;

    tx_state_t   r_state;
    tx_state_t   w_next_state;
    logic [31:0] r_cnt;
    logic [31:0] r_fdiv;
    logic [3:0]  r_bit_idx;
    logic        r_stop_idx;
    logic [8:0]  r_data;
    logic        r_par_bit;
    logic [3:0]  r_nbits;
    logic [1:0]  r_parity;
    logic        r_two_stop;
    logic        w_par_en;
    logic        w_bit_end;
    logic        w_stop_end;
    logic        w_line;

    logic        r_overflow;
    logic        r_tx_serial;
    logic        r_tx_active;
    logic        r_stop_end_d;
    logic        r_tx_done;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Wr_En   (i_Tx_DV),
        .i_Wr_Dat  (i_Tx_Byte),
        .i_Rd_En   (w_pop),
        .o_Rd_Dat  (w_fifo_head),
        .o_Full    (w_fifo_full),
        .o_Empty   (w_fifo_empty),
        .o_Level   (o_Fifo_Level)
    );

    // Divisor: guard the zero case before dividing, then floor the result.
    assign w_den      = (i_BAUD == 32'd0) ? 32'd1 : i_BAUD;
    assign w_quot     = 32'(CLK_FREQ_HZ) / w_den;
    assign w_div_calc = ((i_BAUD == 32'd0) || (w_quot < MIN_DIV)) ? MIN_DIV : w_quot;

    // Character framing: mask off bits above the selected width before storing it.
    assign w_nbits_in  = clamp_data_bits(i_Data_Bits);
    assign w_mask_wide = (10'd1 << w_nbits_in) - 10'd1;
    assign w_char_in   = w_fifo_head & w_mask_wide[8:0];
    assign w_par_en    = (r_parity == PAR_EVEN) || (r_parity == PAR_ODD);

    // Baud divisor register, refreshed every cycle from the live baud input.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_div <= MIN_DIV;
        end else begin
            r_div <= w_div_calc;
        end
    end

    // Sticky overflow: a write strobe that finds the FIFO full.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_overflow <= 1'b0;
        end else if (i_Tx_DV && w_fifo_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Next-state, pop request and line level for the current bit.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_line       = 1'b1;
        w_stop_end   = 1'b0;
        w_bit_end    = (r_cnt == (r_fdiv - 32'd1));
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                w_line = 1'b0;
                if (w_bit_end) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                w_line = r_data[r_bit_idx];
                if (w_bit_end && (r_bit_idx == (r_nbits - 4'd1))) begin
                    w_next_state = w_par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                w_line = r_par_bit;
                if (w_bit_end) begin
                    w_next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_end && (r_stop_idx == r_two_stop)) begin
                    w_stop_end = 1'b1;
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = ST_START;
                    end else begin
                        w_next_state = ST_CLEANUP;
                    end
                end
            end
            ST_CLEANUP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register plus bit timing; frame config is captured whenever a character is popped.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_fdiv     <= MIN_DIV;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_data     <= '0;
            r_par_bit  <= 1'b0;
            r_nbits    <= 4'd8;
            r_parity   <= PAR_NONE;
            r_two_stop <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_pop) begin
                r_cnt      <= '0;
                r_fdiv     <= r_div;
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
                r_data     <= w_char_in;
                r_par_bit  <= (^w_char_in) ^ (i_Parity == PAR_ODD);
                r_nbits    <= w_nbits_in;
                r_parity   <= i_Parity;
                r_two_stop <= i_Stop_Bits;
            end else if (r_state != ST_IDLE && r_state != ST_CLEANUP) begin
                if (w_bit_end) begin
                    r_cnt <= '0;
                    if (r_state == ST_DATA) begin
                        r_bit_idx <= r_bit_idx + 4'd1;
                    end
                    if (r_state == ST_STOP) begin
                        r_stop_idx <= ~r_stop_idx;
                    end
                end else begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
        end
    end

    // Registered pin outputs; done trails the stop-bit end so it lands as the line stop bit finishes.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_tx_serial  <= 1'b1;
            r_tx_active  <= 1'b0;
            r_stop_end_d <= 1'b0;
            r_tx_done    <= 1'b0;
        end else begin
            r_tx_serial  <= w_line;
            r_tx_active  <= (r_state != ST_IDLE) && (r_state != ST_CLEANUP);
            r_stop_end_d <= w_stop_end;
            r_tx_done    <= r_stop_end_d;
        end
    end

    assign o_Tx_Ready  = !w_fifo_full;
    assign o_Overflow  = r_overflow;
    assign o_Tx_Serial = r_tx_serial;
    assign o_Tx_Active = r_tx_active;
    assign o_Tx_Enable = r_tx_active;
    assign o_Tx_Done   = r_tx_done;

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;

    localparam int CLK_HZ = 50_000_000;
    localparam int DEPTH  = 4;
    localparam int MINC   = 4;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   baud;
    logic [3:0]    dbits;
    logic [1:0]    par;
    logic          stop2;
    logic          dv;
    logic [8:0]    byte_in;
    logic          tx_ready;
    logic [LW-1:0] level;
    logic          ovf;
    logic          ser;
    logic          act;
    logic          en;
    logic          done;

    always #5 clk = ~clk;

    uart_tx_param #(
        .CLK_FREQ_HZ      (CLK_HZ),
        .FIFO_DEPTH       (DEPTH),
        .MIN_CLKS_PER_BIT (MINC)
    ) dut (
        .i_Clock      (clk),
        .i_Reset_n    (rst_n),
        .i_BAUD       (baud),
        .i_Data_Bits  (dbits),
        .i_Parity     (par),
        .i_Stop_Bits  (stop2),
        .i_Tx_DV      (dv),
        .i_Tx_Byte    (byte_in),
        .o_Tx_Ready   (tx_ready),
        .o_Fifo_Level (level),
        .o_Overflow   (ovf),
        .o_Tx_Serial  (ser),
        .o_Tx_Active  (act),
        .o_Tx_Enable  (en),
        .o_Tx_Done    (done)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue for the FIFO and an expanded bit list for the frame on the wire.
    int         e_idx     = 0;
    bit         m_busy    = 0;
    int         m_start   = 0;
    int         m_end     = 0;
    int         m_div     = MINC;
    int         m_div_reg = MINC;
    int         m_idle_at = 0;
    int         m_done_at = -1;
    bit         m_ovf     = 0;
    bit         m_bits[$];
    logic [8:0] m_q[$];

    int mm_line, mm_act, mm_en, mm_done, mm_lvl, mm_rdy, mm_ovf;
    int first_bad = -1;
    int dut_done_cnt = 0, dut_act_cnt = 0, exp_done_cnt = 0;

    function automatic int div_of(input logic [31:0] b);
        longint q;
        if (b == 0) return MINC;
        q = longint'(CLK_HZ) / longint'(b);
        return (q < MINC) ? MINC : int'(q);
    endfunction

    function automatic int eff_bits(input logic [3:0] d);
        return (d >= 5 && d <= 9) ? int'(d) : 8;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (first bad edge %0d)", tag, obs, exp, first_bad);
        end
    endtask

    // Build the wire image of one character from the frame rules and the current config inputs.
    task automatic load_frame(input logic [8:0] c);
        int n;
        bit p;
        n = eff_bits(dbits);
        p = 0;
        m_bits.delete();
        m_bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            m_bits.push_back(c[i]);
            p ^= c[i];
        end
        if (par == 2'b01) m_bits.push_back(p);
        if (par == 2'b10) m_bits.push_back(!p);
        m_bits.push_back(1'b1);
        if (stop2) m_bits.push_back(1'b1);
        m_div   = m_div_reg;
        m_start = e_idx;
        m_end   = e_idx + m_bits.size() * m_div;
        m_busy  = 1;
    endtask

    // One clock: drive inputs, advance the model through the edge, then compare after the edge.
    task automatic step(input bit wr, input logic [8:0] c, input bit rst);
        bit x_line, x_act, x_done, full_b, pop;
        int x_lvl;
        rst_n   = !rst;
        dv      = wr;
        byte_in = c;
        e_idx++;
        if (m_busy) begin
            x_act  = 1;
            x_line = m_bits[(e_idx - 1 - m_start) / m_div];
        end else begin
            x_act  = 0;
            x_line = 1;
        end
        x_done = (e_idx == m_done_at);
        if (rst) begin
            m_q.delete();
            m_busy    = 0;
            m_ovf     = 0;
            m_done_at = -1;
            m_div_reg = MINC;
            m_idle_at = e_idx + 1;
            x_line    = 1;
            x_act     = 0;
            x_done    = 0;
        end else begin
            full_b = (m_q.size() >= DEPTH);
            pop    = 0;
            if (m_busy && e_idx == m_end) begin
                m_done_at = e_idx + 1;
                if (m_q.size() > 0) pop = 1;
                else begin
                    m_busy    = 0;
                    m_idle_at = e_idx + 2;
                end
            end else if (!m_busy && e_idx >= m_idle_at && m_q.size() > 0) begin
                pop = 1;
            end
            if (pop) load_frame(m_q.pop_front());
            if (wr) begin
                if (!full_b) m_q.push_back(c);
                else m_ovf = 1;
            end
            m_div_reg = div_of(baud);
        end
        exp_done_cnt += int'(x_done);
        x_lvl = m_q.size();
        @(posedge clk);
        #1;
        if (ser !== x_line) mm_line++;
        if (act !== x_act) mm_act++;
        if (en !== x_act) mm_en++;
        if (done !== x_done) mm_done++;
        if (level !== LW'(x_lvl)) mm_lvl++;
        if (tx_ready !== (x_lvl < DEPTH)) mm_rdy++;
        if (ovf !== m_ovf) mm_ovf++;
        if (first_bad < 0 && (ser !== x_line || act !== x_act || done !== x_done || level !== LW'(x_lvl)))
            first_bad = e_idx;
        if (done === 1'b1) dut_done_cnt++;
        if (act === 1'b1) dut_act_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 9'd0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 6000; i++) begin
            if (!m_busy && m_q.size() == 0 && e_idx > m_idle_at) break;
            step(1'b0, 9'd0, 1'b0);
        end
        idle(2);
    endtask

    task automatic phase_end(input string tag);
        check({tag, ".line_mism"}, mm_line, 0);
        check({tag, ".active_mism"}, mm_act, 0);
        check({tag, ".enable_mism"}, mm_en, 0);
        check({tag, ".done_mism"}, mm_done, 0);
        check({tag, ".level_mism"}, mm_lvl, 0);
        check({tag, ".ready_mism"}, mm_rdy, 0);
        check({tag, ".overflow_mism"}, mm_ovf, 0);
        check({tag, ".done_count"}, dut_done_cnt, exp_done_cnt);
        mm_line = 0; mm_act = 0; mm_en = 0; mm_done = 0;
        mm_lvl = 0; mm_rdy = 0; mm_ovf = 0; first_bad = -1;
        dut_done_cnt = 0; dut_act_cnt = 0; exp_done_cnt = 0;
    endtask

    initial begin
        int w;
        mm_line = 0; mm_act = 0; mm_en = 0; mm_done = 0;
        mm_lvl = 0; mm_rdy = 0; mm_ovf = 0;
        baud = 32'd5_000_000; dbits = 4'd8; par = 2'b00; stop2 = 1'b0;
        dv = 1'b0; byte_in = 9'd0; rst_n = 1'b0;

        // Reset values
        step(1'b0, 9'd0, 1'b1);
        step(1'b0, 9'd0, 1'b1);
        check("rst.serial", ser, 1);
        check("rst.active", act, 0);
        check("rst.enable", en, 0);
        check("rst.done", done, 0);
        check("rst.level", level, 0);
        check("rst.ready", tx_ready, 1);
        check("rst.overflow", ovf, 0);
        idle(3);
        phase_end("rst");

        // 8N1 0xA5 at div 10
        step(1'b1, 9'h0A5, 1'b0);
        step(1'b0, 9'd0, 1'b0);
        check("t1.line_at_w1", ser, 1);
        step(1'b0, 9'd0, 1'b0);
        check("t1.start_at_w2", ser, 0);
        drain();
        check("t1.active_cycles", dut_act_cnt, 100);
        check("t1.done_pulses", dut_done_cnt, 1);
        phase_end("t1");

        // 7E2 0x41
        dbits = 4'd7; par = 2'b01; stop2 = 1'b1;
        idle(2);
        step(1'b1, 9'h041, 1'b0);
        drain();
        check("t2.active_cycles", dut_act_cnt, 110);
        phase_end("t2");

        // 9O1 0x1FF
        dbits = 4'd9; par = 2'b10; stop2 = 1'b0;
        idle(2);
        step(1'b1, 9'h1FF, 1'b0);
        drain();
        check("t3.active_cycles", dut_act_cnt, 120);
        phase_end("t3");

        // Burst of six writes into a depth-4 FIFO
        dbits = 4'd8; par = 2'b00; stop2 = 1'b0;
        idle(2);
        for (int i = 0; i < 6; i++) step(1'b1, 9'(8'h11 + i), 1'b0);
        check("t4.overflow", ovf, 1);
        check("t4.ready_full", tx_ready, 0);
        check("t4.level_full", level, DEPTH);
        drain();
        check("t4.active_contiguous", dut_act_cnt, 100 * dut_done_cnt);
        phase_end("t4");

        // Divisor floor for zero and over-fast baud
        baud = 32'd0;
        idle(2);
        step(1'b1, 9'h03C, 1'b0);
        drain();
        check("t5.baud0_active", dut_act_cnt, 40);
        phase_end("t5a");
        baud = 32'd100_000_000;
        idle(2);
        step(1'b1, 9'h0C3, 1'b0);
        drain();
        check("t5.baud100M_active", dut_act_cnt, 40);
        phase_end("t5b");

        // Baud change mid-frame leaves the current frame alone
        baud = 32'd5_000_000;
        idle(2);
        step(1'b1, 9'h05A, 1'b0);
        idle(20);
        baud = 32'd0;
        drain();
        check("t5.midframe_active", dut_act_cnt, 100);
        phase_end("t5c");

        // Reset during data bit 3 with a second character queued
        baud = 32'd5_000_000;
        idle(2);
        step(1'b1, 9'h0F0, 1'b0);
        step(1'b1, 9'h00F, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (m_busy && (e_idx + 1 - m_start) == 4 * m_div + 5) break;
            step(1'b0, 9'd0, 1'b0);
        end
        check("t6.line_before_reset", ser, 0);
        step(1'b0, 9'd0, 1'b1);
        check("t6.line_after_reset", ser, 1);
        check("t6.active_after_reset", act, 0);
        check("t6.level_after_reset", level, 0);
        idle(40);
        check("t6.no_done", dut_done_cnt, 0);
        phase_end("t6");

        // Random characters, configs and gaps, including out-of-range widths and config changes mid-frame
        for (int r = 0; r < 14; r++) begin
            dbits = 4'($urandom_range(3, 11));
            par   = 2'($urandom_range(0, 3));
            stop2 = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       baud = 32'd0;
                1:       baud = 32'd200_000_000;
                default: baud = 32'($urandom_range(3_000_000, 14_000_000));
            endcase
            w = $urandom_range(1, 3);
            for (int k = 0; k < w; k++) step(1'b1, 9'($urandom_range(0, 511)), 1'b0);
            idle($urandom_range(0, 60));
        end
        drain();
        phase_end("rnd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
